// File: rtl/single_port_rom_reg_if.sv
// rtl/single_port_rom_reg_if.sv - read bus between a controller and the single-port ROM
// Optional port data_parity is present when SINGLE_PORT_ROM_PARITY_EN is defined.
interface single_port_rom_reg_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              addr_err;
`ifdef SINGLE_PORT_ROM_PARITY_EN
  logic              data_parity;
`endif

`ifdef SINGLE_PORT_ROM_PARITY_EN
  // Controller side: issues reads, consumes registered results.
  modport master (
    output rd_en, addr,
    input  data_out, data_valid, addr_err, data_parity
  );

  // ROM side: samples reads, drives registered results.
  modport slave (
    input  rd_en, addr,
    output data_out, data_valid, addr_err, data_parity
  );
`else
  // Controller side: issues reads, consumes registered results.
  modport master (
    output rd_en, addr,
    input  data_out, data_valid, addr_err
  );

  // ROM side: samples reads, drives registered results.
  modport slave (
    input  rd_en, addr,
    output data_out, data_valid, addr_err
  );
`endif
endinterface

// File: rtl/single_port_rom_reg.sv
// rtl/single_port_rom_reg.sv - fixed 8-entry lookup ROM with registered output, valid strobe and range error
// Optional feature: SINGLE_PORT_ROM_PARITY_EN adds a registered even-parity bit (data_parity).
module single_port_rom_reg #(
  parameter int                ADDR_W       = 3,
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 8,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  single_port_rom_reg_if.slave bus
);

  logic [31:0]       addr_ext;
  logic              in_range;
  logic [7:0]        base_word;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              err_q;

  // Widen the address so the range compare works for any ADDR_W/DEPTH pair.
  always_comb begin
    addr_ext = 32'(bus.addr);
    in_range = (addr_ext < 32'(DEPTH));
  end

  // Base table; implemented entries repeat it every 8 words when DEPTH > 8.
  always_comb begin
    base_word = 8'h00;
    case (addr_ext[2:0])
      3'd0:    base_word = 8'hA5;
      3'd1:    base_word = 8'h3C;
      3'd2:    base_word = 8'h7E;
      3'd3:    base_word = 8'h01;
      3'd4:    base_word = 8'hFF;
      3'd5:    base_word = 8'h80;
      3'd6:    base_word = 8'h5A;
      3'd7:    base_word = 8'hC3;
      default: base_word = 8'h00;
    endcase
  end

  // Fit the table byte to DATA_W (zero-extend or truncate); unimplemented addresses read DEFAULT_WORD.
  always_comb begin
    rd_word = in_range ? DATA_W'(base_word) : DEFAULT_WORD;
  end

  // Output register: loads only on an accepted read so an idle (or X) address cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        data_q <= rd_word;
        err_q  <= !in_range;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.addr_err   = err_q;

`ifdef SINGLE_PORT_ROM_PARITY_EN
  logic parity_q;

  // Parity is registered with the word so the pair always describes the same read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (bus.rd_en) begin
      parity_q <= ^rd_word;
    end
  end

  assign bus.data_parity = parity_q;
`endif

endmodule

// File: tb/tb_single_port_rom_reg.sv
// tb/tb_single_port_rom_reg.sv - directed self-checking bench for single_port_rom_reg
module tb_single_port_rom_reg;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  logic [7:0] exp_tab [8];

  single_port_rom_reg_if #(.ADDR_W(3), .DATA_W(8)) bus8 ();
  single_port_rom_reg_if #(.ADDR_W(3), .DATA_W(8)) bus6 ();

  single_port_rom_reg #(.ADDR_W(3), .DATA_W(8), .DEPTH(8), .DEFAULT_WORD(8'h00)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  single_port_rom_reg #(.ADDR_W(3), .DATA_W(8), .DEPTH(6), .DEFAULT_WORD(8'h00)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [2:0] a);
    bus8.rd_en = en;
    bus8.addr  = a;
    bus6.rd_en = en;
    bus6.addr  = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 3'd3);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus8.data_out !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus8.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus8.data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus8.data_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus8.addr_err !== 1'b0 || bus6.addr_err !== 1'b0)
      $display("FAIL reset_err got=%b/%b exp=0/0", bus8.addr_err, bus6.addr_err);
    else pass_cnt++;
    // release, load a nonzero word, then assert reset between edges
    rst_n = 1'b1;
    drive(1'b1, 3'd4);
    @(negedge clk);
    drive(1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus8.data_out !== 8'h00 || bus8.data_valid !== 1'b0)
      $display("FAIL async_reset got=%h/%b exp=00/0", bus8.data_out, bus8.data_valid);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    drive(1'b1, 3'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus8.data_out !== exp_tab[i] || bus8.data_valid !== 1'b1 || bus8.addr_err !== 1'b0)
        $display("FAIL sweep_%0d got=%h/%b/%b exp=%h/1/0", i, bus8.data_out, bus8.data_valid,
                 bus8.addr_err, exp_tab[i]);
      else pass_cnt++;
      if (i < 7) drive(1'b1, 3'(i + 1));
      else drive(1'b0, 3'd0);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 3'd4);
    @(negedge clk);
    total_cnt++;
    if (bus8.data_out !== 8'hFF || bus8.data_valid !== 1'b1)
      $display("FAIL hold_load got=%h/%b exp=FF/1", bus8.data_out, bus8.data_valid);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'(2 * k + 1));
      @(negedge clk);
      total_cnt++;
      if (bus8.data_out !== 8'hFF || bus8.data_valid !== 1'b0)
        $display("FAIL hold_%0d got=%h/%b exp=FF/0", k, bus8.data_out, bus8.data_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 3'd5);
    @(negedge clk);
    total_cnt++;
    if (bus6.data_out !== 8'h80 || bus6.addr_err !== 1'b0)
      $display("FAIL oor_pre got=%h/%b exp=80/0", bus6.data_out, bus6.addr_err);
    else pass_cnt++;
    drive(1'b1, 3'd6);
    @(negedge clk);
    total_cnt++;
    if (bus6.data_out !== 8'h00 || bus6.addr_err !== 1'b1 || bus6.data_valid !== 1'b1)
      $display("FAIL oor_6 got=%h/%b/%b exp=00/1/1", bus6.data_out, bus6.addr_err, bus6.data_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus8.data_out !== 8'h5A || bus8.addr_err !== 1'b0)
      $display("FAIL full_depth_6 got=%h/%b exp=5A/0", bus8.data_out, bus8.addr_err);
    else pass_cnt++;
    drive(1'b1, 3'd7);
    @(negedge clk);
    total_cnt++;
    if (bus6.data_out !== 8'h00 || bus6.addr_err !== 1'b1)
      $display("FAIL oor_7 got=%h/%b exp=00/1", bus6.data_out, bus6.addr_err);
    else pass_cnt++;
    total_cnt++;
    if (bus8.data_out !== 8'hC3 || bus8.addr_err !== 1'b0)
      $display("FAIL full_depth_7 got=%h/%b exp=C3/0", bus8.data_out, bus8.addr_err);
    else pass_cnt++;
    drive(1'b0, 3'd2);
    @(negedge clk);
    total_cnt++;
    if (bus6.addr_err !== 1'b1 || bus6.data_valid !== 1'b0)
      $display("FAIL oor_hold got=%b/%b exp=1/0", bus6.addr_err, bus6.data_valid);
    else pass_cnt++;
    drive(1'b1, 3'd5);
    @(negedge clk);
    total_cnt++;
    if (bus6.data_out !== 8'h80 || bus6.addr_err !== 1'b0)
      $display("FAIL oor_recover got=%h/%b exp=80/0", bus6.data_out, bus6.addr_err);
    else pass_cnt++;
    drive(1'b0, 3'd0);
  endtask

  task automatic test_mid_read_reset();
    drive(1'b1, 3'd2);
    #4 rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus8.data_out !== 8'h00 || bus8.data_valid !== 1'b0)
      $display("FAIL midreset got=%h/%b exp=00/0", bus8.data_out, bus8.data_valid);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus8.data_out !== 8'h7E || bus8.data_valid !== 1'b1)
      $display("FAIL midreset_after got=%h/%b exp=7E/1", bus8.data_out, bus8.data_valid);
    else pass_cnt++;
    drive(1'b0, 3'd0);
    @(negedge clk);
  endtask

`ifdef SINGLE_PORT_ROM_PARITY_EN
  task automatic test_parity();
    logic [2:0] pa [3];
    logic       pe [3];
    pa[0] = 3'd0; pe[0] = 1'b0;
    pa[1] = 3'd3; pe[1] = 1'b1;
    pa[2] = 3'd4; pe[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pa[i]);
      @(negedge clk);
      total_cnt++;
      if (bus8.data_parity !== pe[i])
        $display("FAIL parity_%0d got=%b exp=%b", i, bus8.data_parity, pe[i]);
      else pass_cnt++;
    end
    drive(1'b1, 3'd6);
    @(negedge clk);
    total_cnt++;
    if (bus6.data_parity !== 1'b0)
      $display("FAIL parity_default got=%b exp=0", bus6.data_parity);
    else pass_cnt++;
    drive(1'b0, 3'd0);
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_tab[0] = 8'hA5; exp_tab[1] = 8'h3C; exp_tab[2] = 8'h7E; exp_tab[3] = 8'h01;
    exp_tab[4] = 8'hFF; exp_tab[5] = 8'h80; exp_tab[6] = 8'h5A; exp_tab[7] = 8'hC3;
    rst_n = 1'b0;
    drive(1'b0, 3'd0);
    test_reset();
    test_sweep();
    test_hold();
    test_out_of_range();
    test_mid_read_reset();
`ifdef SINGLE_PORT_ROM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/single_port_rom_reg.md
Name: single_port_rom_reg

Overview:
- Synchronous single-port read-only memory with a fixed 8-entry lookup table, a read enable, and a registered output.
- Serves as a small constant/coefficient store read by a controller.
- Supplies one word per enabled read, one clock after the address is presented, with a valid strobe and an address-range error flag.

Parameters:
- ADDR_W, 3, address width in bits.
- DATA_W, 8, data word width in bits.
- DEPTH, 8, number of implemented entries; legal range 1..2^ADDR_W.
- DEFAULT_WORD, 0, value returned for addresses >= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_en  input  1  read request, sampled on the rising edge of clk.
- addr  input  ADDR_W  read address, sampled with rd_en.
- data_out  output  DATA_W  registered read data.
- data_valid  output  1  high for exactly one cycle per accepted read.
- addr_err  output  1  registered flag: the last accepted read had addr >= DEPTH.

Behaviour:
- Base table, index 0..7: A5, 3C, 7E, 01, FF, 80, 5A, C3 (hex, 8-bit).
- Entry i, for i < DEPTH, is table[i mod 8].
  - If DATA_W > 8, zero-extend the table value.
  - If DATA_W < 8, keep the low DATA_W bits.
- Contents are constant. There is no write path, and no port or parameter alters contents.
- Reset (rst_n low, asynchronous, no clock needed): data_out = 0, data_valid = 0, addr_err = 0. These values hold while rst_n is low.
- Reset release is synchronous to clk: the first edge with rst_n high may accept a read.
- Read, on a rising edge with rd_en = 1:
  - data_out <= entry[addr], or DEFAULT_WORD if addr >= DEPTH.
  - addr_err <= (addr >= DEPTH).
  - data_valid <= 1.
  - Latency: exactly 1 cycle.
- Rising edge with rd_en = 0: data_out and addr_err hold their last values; data_valid <= 0.
- Back-to-back reads on consecutive edges: full throughput, one result per cycle, returned in request order.
- Address wrap-around: none. Addresses are not reduced modulo DEPTH.
- X/Z on addr while rd_en = 0 must not disturb any output.
- Reset asserted mid-read: the in-flight result is discarded and outputs go to their reset values immediately.
- Purely combinational paths from inputs to outputs are not permitted; all outputs are flop-driven.

Optional Feature:
- Macro: SINGLE_PORT_ROM_PARITY_EN.
- Defined:
  - Adds output port data_parity (1 bit), registered alongside data_out.
  - data_parity = XOR of all DATA_W bits of the word loaded into data_out, i.e. even parity over data_out plus data_parity.
  - Reset value 0; holds when rd_en = 0.
  - For out-of-range reads, parity is computed over DEFAULT_WORD.
- Undefined: the port is absent and no parity logic is generated; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with clk toggling and rd_en = 1 -> data_out = 00, data_valid = 0, addr_err = 0. Assert rst_n asynchronously between edges -> outputs clear without waiting for a clock edge.
- Sequential sweep: rd_en = 1, addr = 0..7 on consecutive edges -> one cycle later data_out = A5, 3C, 7E, 01, FF, 80, 5A, C3 in order; data_valid = 1 each cycle; addr_err = 0.
- Hold: read addr = 4, then rd_en = 0 for 3 cycles with addr changing -> data_out stays FF, data_valid = 1 for one cycle then 0.
- Out of range: DEPTH = 6, read addr = 6 and addr = 7 -> data_out = DEFAULT_WORD (00), addr_err = 1. A following read of addr = 5 -> data_out = 80, addr_err = 0.
- Mid-read reset: rd_en = 1, addr = 2, pull rst_n low just before the edge -> data_out = 00, data_valid = 0 after reset. After release, a read of addr = 2 -> 7E.
- Parity (macro defined): reads of addr 0, 3, 4 -> data_parity = 0, 1, 0 (A5 has 4 ones, 01 has 1 one, FF has 8 ones).
